// File: rtl/alu_rs.sv
// Reservation station in front of the ALU: buffers issued ops, wakes pending
// operands on ALU/LSB broadcasts and dispatches one ready op per cycle.
module alu_rs #(
    parameter int RS_SIZE   = 8,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_op,
    input  logic [31:0]          issue_vj,
    input  logic [31:0]          issue_vk,
    input  logic                 issue_qj_busy,
    input  logic [ROB_WIDTH-1:0] issue_qj,
    input  logic                 issue_qk_busy,
    input  logic [ROB_WIDTH-1:0] issue_qk,
    input  logic [ROB_WIDTH-1:0] issue_rob_id,
    input  logic [31:0]          issue_true_jaddr,
    input  logic [31:0]          issue_false_jaddr,
    input  logic                 alu_ready,
    input  logic [ROB_WIDTH-1:0] alu_rob_id,
    input  logic [31:0]          alu_value,
    input  logic                 lsb_ready,
    input  logic [ROB_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]          lsb_value,
    output logic                 full,
    output logic                 calc_enable,
    output logic [31:0]          lhs,
    output logic [31:0]          rhs,
    output logic [4:0]           op,
    output logic [ROB_WIDTH-1:0] rob_dep,
    output logic [31:0]          true_jaddr,
    output logic [31:0]          false_jaddr
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]   valid;
    logic [RS_SIZE-1:0]   qj_busy;
    logic [RS_SIZE-1:0]   qk_busy;
    logic [4:0]           op_q  [RS_SIZE];
    logic [31:0]          vj_q  [RS_SIZE];
    logic [31:0]          vk_q  [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj_q  [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk_q  [RS_SIZE];
    logic [ROB_WIDTH-1:0] rob_q [RS_SIZE];
    logic [31:0]          tj_q  [RS_SIZE];
    logic [31:0]          fj_q  [RS_SIZE];

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             in_qj_busy;
    logic             in_qk_busy;
    logic [31:0]      in_vj;
    logic [31:0]      in_vk;

    assign full = &valid;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (valid[i] && !qj_busy[i] && !qk_busy[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Incoming operands can be satisfied by a broadcast in the same cycle.
    always_comb begin
        in_qj_busy = issue_qj_busy;
        in_vj      = issue_vj;
        in_qk_busy = issue_qk_busy;
        in_vk      = issue_vk;
        if (issue_qj_busy) begin
            if (alu_ready && alu_rob_id == issue_qj) begin
                in_qj_busy = 1'b0;
                in_vj      = alu_value;
            end else if (lsb_ready && lsb_rob_id == issue_qj) begin
                in_qj_busy = 1'b0;
                in_vj      = lsb_value;
            end
        end
        if (issue_qk_busy) begin
            if (alu_ready && alu_rob_id == issue_qk) begin
                in_qk_busy = 1'b0;
                in_vk      = alu_value;
            end else if (lsb_ready && lsb_rob_id == issue_qk) begin
                in_qk_busy = 1'b0;
                in_vk      = lsb_value;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid       <= '0;
            qj_busy     <= '0;
            qk_busy     <= '0;
            calc_enable <= 1'b0;
            lhs         <= '0;
            rhs         <= '0;
            op          <= '0;
            rob_dep     <= '0;
            true_jaddr  <= '0;
            false_jaddr <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                rob_q[i] <= '0;
                tj_q[i]  <= '0;
                fj_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (clear) begin
                valid       <= '0;
                calc_enable <= 1'b0;
                lhs         <= '0;
                rhs         <= '0;
                op          <= '0;
                rob_dep     <= '0;
                true_jaddr  <= '0;
                false_jaddr <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (valid[i] && qj_busy[i]) begin
                        if (alu_ready && alu_rob_id == qj_q[i]) begin
                            vj_q[i]    <= alu_value;
                            qj_busy[i] <= 1'b0;
                        end else if (lsb_ready && lsb_rob_id == qj_q[i]) begin
                            vj_q[i]    <= lsb_value;
                            qj_busy[i] <= 1'b0;
                        end
                    end
                    if (valid[i] && qk_busy[i]) begin
                        if (alu_ready && alu_rob_id == qk_q[i]) begin
                            vk_q[i]    <= alu_value;
                            qk_busy[i] <= 1'b0;
                        end else if (lsb_ready && lsb_rob_id == qk_q[i]) begin
                            vk_q[i]    <= lsb_value;
                            qk_busy[i] <= 1'b0;
                        end
                    end
                end

                // Dispatch slot is valid and issue slot is invalid, so they never collide.
                if (sel_found) begin
                    calc_enable    <= 1'b1;
                    lhs            <= vj_q[sel_idx];
                    rhs            <= vk_q[sel_idx];
                    op             <= op_q[sel_idx];
                    rob_dep        <= rob_q[sel_idx];
                    true_jaddr     <= tj_q[sel_idx];
                    false_jaddr    <= fj_q[sel_idx];
                    valid[sel_idx] <= 1'b0;
                end else begin
                    calc_enable <= 1'b0;
                    lhs         <= '0;
                    rhs         <= '0;
                    op          <= '0;
                    rob_dep     <= '0;
                    true_jaddr  <= '0;
                    false_jaddr <= '0;
                end

                if (issue_valid && free_found) begin
                    valid[free_idx]   <= 1'b1;
                    qj_busy[free_idx] <= in_qj_busy;
                    qk_busy[free_idx] <= in_qk_busy;
                    vj_q[free_idx]    <= in_vj;
                    vk_q[free_idx]    <= in_vk;
                    qj_q[free_idx]    <= issue_qj;
                    qk_q[free_idx]    <= issue_qk;
                    op_q[free_idx]    <= issue_op;
                    rob_q[free_idx]   <= issue_rob_id;
                    tj_q[free_idx]    <= issue_true_jaddr;
                    fj_q[free_idx]    <= issue_false_jaddr;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs: dispatch latency, wakeup, bypass,
// full handling, flush, stall and asynchronous reset.
module tb_alu_rs;
    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        issue_valid;
    logic [4:0]  issue_op;
    logic [31:0] issue_vj;
    logic [31:0] issue_vk;
    logic        issue_qj_busy;
    logic [3:0]  issue_qj;
    logic        issue_qk_busy;
    logic [3:0]  issue_qk;
    logic [3:0]  issue_rob_id;
    logic [31:0] issue_true_jaddr;
    logic [31:0] issue_false_jaddr;
    logic        alu_ready;
    logic [3:0]  alu_rob_id;
    logic [31:0] alu_value;
    logic        lsb_ready;
    logic [3:0]  lsb_rob_id;
    logic [31:0] lsb_value;
    logic        full;
    logic        calc_enable;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [4:0]  op;
    logic [3:0]  rob_dep;
    logic [31:0] true_jaddr;
    logic [31:0] false_jaddr;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_rs #(.RS_SIZE(8), .ROB_WIDTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj),
        .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk),
        .issue_rob_id(issue_rob_id),
        .issue_true_jaddr(issue_true_jaddr), .issue_false_jaddr(issue_false_jaddr),
        .alu_ready(alu_ready), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .full(full), .calc_enable(calc_enable), .lhs(lhs), .rhs(rhs), .op(op),
        .rob_dep(rob_dep), .true_jaddr(true_jaddr), .false_jaddr(false_jaddr)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Branch targets are derived from the ROB id so every dispatch is traceable.
    task automatic applyStimulus(input logic [4:0] o, input logic [31:0] vj,
                                 input logic [31:0] vk, input logic qjb,
                                 input logic [3:0] qj, input logic qkb,
                                 input logic [3:0] qk, input logic [3:0] rob);
        issue_valid       = 1'b1;
        issue_op          = o;
        issue_vj          = vj;
        issue_vk          = vk;
        issue_qj_busy     = qjb;
        issue_qj          = qj;
        issue_qk_busy     = qkb;
        issue_qk          = qk;
        issue_rob_id      = rob;
        issue_true_jaddr  = 32'h1000 + 32'(rob);
        issue_false_jaddr = 32'h2000 + 32'(rob);
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        alu_ready   = 1'b0;
        lsb_ready   = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic aluBroadcast(input logic [3:0] tag, input logic [31:0] val);
        alu_ready  = 1'b1;
        alu_rob_id = tag;
        alu_value  = val;
    endtask

    task automatic lsbBroadcast(input logic [3:0] tag, input logic [31:0] val);
        lsb_ready  = 1'b1;
        lsb_rob_id = tag;
        lsb_value  = val;
    endtask

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        alu_rob_id = '0; alu_value = '0; lsb_rob_id = '0; lsb_value = '0;
        applyStimulus(5'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
        idle();
        #1;
        checkOutput("reset_calc_enable", 32'(calc_enable), 32'd0);
        checkOutput("reset_full", 32'(full), 32'd0);
        tick();
        tick();
        rst_in = 1'b1;
        checkOutput("reset_lhs", lhs, 32'd0);

        // Ready ADD: one-edge issue, dispatch on the next edge
        applyStimulus(5'd0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        tick();
        idle();
        checkOutput("t1_not_yet", 32'(calc_enable), 32'd0);
        tick();
        checkOutput("t1_calc_enable", 32'(calc_enable), 32'd1);
        checkOutput("t1_lhs", lhs, 32'd5);
        checkOutput("t1_rhs", rhs, 32'd7);
        checkOutput("t1_op", 32'(op), 32'd0);
        checkOutput("t1_rob_dep", 32'(rob_dep), 32'd3);
        checkOutput("t1_true_jaddr", true_jaddr, 32'h1003);
        checkOutput("t1_false_jaddr", false_jaddr, 32'h2003);
        tick();
        checkOutput("t1_after_en", 32'(calc_enable), 32'd0);
        checkOutput("t1_after_lhs", lhs, 32'd0);
        checkOutput("t1_after_rhs", rhs, 32'd0);

        // lhs waits on tag 2, woken by the ALU broadcast
        applyStimulus(5'd1, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd6);
        tick();
        idle();
        tick();
        checkOutput("t2_pending", 32'(calc_enable), 32'd0);
        aluBroadcast(4'd2, 32'h10);
        tick();
        idle();
        checkOutput("t2_capture_edge", 32'(calc_enable), 32'd0);
        tick();
        checkOutput("t2_calc_enable", 32'(calc_enable), 32'd1);
        checkOutput("t2_lhs", lhs, 32'h10);
        checkOutput("t2_rhs", rhs, 32'd1);
        checkOutput("t2_op", 32'(op), 32'd1);
        checkOutput("t2_rob_dep", 32'(rob_dep), 32'd6);
        tick();

        // Issue bypass from the LSB broadcast on the rhs
        applyStimulus(5'd2, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd5, 4'd7);
        lsbBroadcast(4'd5, 32'hAB);
        tick();
        idle();
        tick();
        checkOutput("t3_calc_enable", 32'(calc_enable), 32'd1);
        checkOutput("t3_rhs", rhs, 32'hAB);
        checkOutput("t3_lhs", lhs, 32'd3);
        tick();

        // Bypass with both broadcasts on the same tag: ALU value wins
        applyStimulus(5'd3, 32'd0, 32'h400, 1'b1, 4'd9, 1'b0, 4'd0, 4'd1);
        aluBroadcast(4'd9, 32'h11);
        lsbBroadcast(4'd9, 32'h22);
        tick();
        idle();
        tick();
        checkOutput("t3b_calc_enable", 32'(calc_enable), 32'd1);
        checkOutput("t3b_alu_wins", lhs, 32'h11);
        checkOutput("t3b_rhs_full_width", rhs, 32'h400);
        tick();

        // Fill all 8 slots: slot i waits on tag 8+i and carries rob i
        for (int i = 0; i < 8; i++) begin
            applyStimulus(5'd4, 32'd0, 32'd0, 1'b1, 4'(8 + i), 1'b0, 4'd0, 4'(i));
            tick();
            if (i == 6) checkOutput("t4_full_at_7", 32'(full), 32'd0);
        end
        idle();
        checkOutput("t4_full_at_8", 32'(full), 32'd1);
        applyStimulus(5'd5, 32'h99, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
        tick();
        idle();
        checkOutput("t4_ignored_full", 32'(full), 32'd1);
        tick();
        checkOutput("t4_ignored_no_dispatch", 32'(calc_enable), 32'd0);
        aluBroadcast(4'd12, 32'h44);
        tick();
        idle();
        checkOutput("t4_wake_edge_en", 32'(calc_enable), 32'd0);
        checkOutput("t4_wake_edge_full", 32'(full), 32'd1);
        tick();
        checkOutput("t4_dispatch_en", 32'(calc_enable), 32'd1);
        checkOutput("t4_dispatch_lhs", lhs, 32'h44);
        checkOutput("t4_dispatch_rob", 32'(rob_dep), 32'd4);
        checkOutput("t4_full_dropped", 32'(full), 32'd0);
        applyStimulus(5'd6, 32'h55, 32'h66, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        tick();
        idle();
        checkOutput("t4_refill_full", 32'(full), 32'd1);
        tick();
        checkOutput("t4_refill_rob", 32'(rob_dep), 32'd9);
        checkOutput("t4_refill_lhs", lhs, 32'h55);
        // Wake slots 2 and 6 together: lowest index dispatches first
        aluBroadcast(4'd14, 32'h6);
        lsbBroadcast(4'd10, 32'h2);
        tick();
        idle();
        tick();
        checkOutput("t4_select_first", 32'(rob_dep), 32'd2);
        checkOutput("t4_select_first_lhs", lhs, 32'h2);
        tick();
        checkOutput("t4_select_second", 32'(rob_dep), 32'd6);
        checkOutput("t4_select_second_lhs", lhs, 32'h6);

        // Flush with live entries (tags 8,9,11,13,15) and a same-cycle issue
        applyStimulus(5'd7, 32'h1, 32'h2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
        clear = 1'b1;
        tick();
        idle();
        checkOutput("t5_calc_enable", 32'(calc_enable), 32'd0);
        checkOutput("t5_full", 32'(full), 32'd0);
        aluBroadcast(4'd8, 32'h1);
        lsbBroadcast(4'd9, 32'h1);
        tick();
        checkOutput("t5_no_issue_dispatch", 32'(calc_enable), 32'd0);
        aluBroadcast(4'd11, 32'h1);
        lsbBroadcast(4'd13, 32'h1);
        tick();
        checkOutput("t5_wake_a", 32'(calc_enable), 32'd0);
        aluBroadcast(4'd15, 32'h1);
        tick();
        idle();
        checkOutput("t5_wake_b", 32'(calc_enable), 32'd0);
        tick();
        checkOutput("t5_wake_c", 32'(calc_enable), 32'd0);

        // Stall with a live dispatch, then async reset mid-stall
        applyStimulus(5'd3, 32'hDEAD, 32'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
        tick();
        idle();
        tick();
        checkOutput("t6_calc_enable", 32'(calc_enable), 32'd1);
        rdy_in = 1'b0;
        applyStimulus(5'd8, 32'h77, 32'h88, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t6_hold_en", 32'(calc_enable), 32'd1);
            checkOutput("t6_hold_lhs", lhs, 32'hDEAD);
            checkOutput("t6_hold_rhs", rhs, 32'hBEEF);
        end
        #2;
        rst_in = 1'b0;
        #1;
        checkOutput("t6_async_en", 32'(calc_enable), 32'd0);
        checkOutput("t6_async_lhs", lhs, 32'd0);
        checkOutput("t6_async_rob", 32'(rob_dep), 32'd0);
        idle();
        tick();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        tick();
        tick();
        checkOutput("t6_post_reset_en", 32'(calc_enable), 32'd0);
        checkOutput("t6_post_reset_full", 32'(full), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
